// File: rtl/minicpu_multicycle.sv
// minicpu_multicycle: multi-cycle LoongArch-subset core with req/ready memories.
// Define MINICPU_TRACE_EN to add the debug_wb_* retire trace outputs.
module minicpu_regfile (
  input  logic        clk,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);
  logic [31:0] r_mem [32];

  always_ff @(posedge clk) begin
    if (i_we && i_waddr != 5'd0) r_mem[i_waddr] <= i_wdata;
  end

  // r0 is hardwired to zero on the read side; entry 0 is never written
  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : r_mem[i_raddr2];
endmodule

module minicpu_multicycle #(
  parameter logic [31:0] RESET_PC  = 32'h1c000000,
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 inst_req,
  output logic [31:0]          inst_addr,
  input  logic [31:0]          inst_rdata,
  input  logic                 inst_ready,
  output logic                 data_req,
  output logic                 data_we,
  output logic [31:0]          data_addr,
  output logic [31:0]          data_wdata,
  input  logic [31:0]          data_rdata,
  input  logic                 data_ready,
  output logic [INSTRET_W-1:0] instret
`ifdef MINICPU_TRACE_EN
  ,
  output logic [31:0]          debug_wb_pc,
  output logic                 debug_wb_rf_we,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata
`endif
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  logic [2:0]           r_state;
  logic [31:0]          r_pc;
  logic [31:0]          r_ir;
  logic [31:0]          r_a;
  logic [31:0]          r_b;
  logic [31:0]          r_alu;
  logic [31:0]          r_mdr;
  logic [INSTRET_W-1:0] r_instret;

  logic        w_add, w_sub, w_addi, w_ld, w_st, w_beq, w_bne;
  logic        w_is_mem, w_is_alu, w_taken, w_retire, w_rf_we;
  logic [4:0]  w_rd, w_rj, w_rk, w_raddr2;
  logic [31:0] w_simm12, w_boffs, w_alu_res, w_pc_next, w_wb_data;
  logic [31:0] w_rdata1, w_rdata2;

  assign w_add  = (r_ir[31:15] == 17'h00020);
  assign w_sub  = (r_ir[31:15] == 17'h00022);
  assign w_addi = (r_ir[31:22] == 10'h00a);
  assign w_ld   = (r_ir[31:22] == 10'h0a2);
  assign w_st   = (r_ir[31:22] == 10'h0a6);
  assign w_beq  = (r_ir[31:26] == 6'h16);
  assign w_bne  = (r_ir[31:26] == 6'h17);

  assign w_rd     = r_ir[4:0];
  assign w_rj     = r_ir[9:5];
  assign w_rk     = r_ir[14:10];
  assign w_simm12 = {{20{r_ir[21]}}, r_ir[21:10]};
  assign w_boffs  = {{14{r_ir[25]}}, r_ir[25:10], 2'b00};

  assign w_is_mem = w_ld | w_st;
  assign w_is_alu = w_add | w_sub | w_addi;
  assign w_raddr2 = (w_st | w_beq | w_bne) ? w_rd : w_rk;

  assign w_alu_res = w_add ? (r_a + r_b) :
                     w_sub ? (r_a - r_b) :
                             (r_a + w_simm12);

  assign w_taken   = (w_beq & (r_a == r_b)) | (w_bne & (r_a != r_b));
  assign w_pc_next = w_taken ? (r_pc + w_boffs) : (r_pc + 32'd4);

  // branches and unknown encodings retire straight out of EXEC
  assign w_retire = ((r_state == S_EXEC) & ~w_is_mem & ~w_is_alu)
                  | ((r_state == S_MEM) & data_ready & w_st)
                  | (r_state == S_WB);

  assign w_rf_we   = (r_state == S_WB);
  assign w_wb_data = w_ld ? r_mdr : r_alu;

  minicpu_regfile u_rf (
    .clk      (clk),
    .i_raddr1 (w_rj),
    .i_raddr2 (w_raddr2),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2),
    .i_we     (w_rf_we),
    .i_waddr  (w_rd),
    .i_wdata  (w_wb_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu     <= '0;
      r_mdr     <= '0;
      r_instret <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (inst_ready) begin
            r_ir    <= inst_rdata;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a     <= w_rdata1;
          r_b     <= w_rdata2;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_alu <= w_alu_res;
          if (w_is_mem)      r_state <= S_MEM;
          else if (w_is_alu) r_state <= S_WB;
          else               r_state <= S_FETCH;
        end
        S_MEM: begin
          if (data_ready) begin
            r_mdr   <= data_rdata;
            r_state <= w_st ? S_FETCH : S_WB;
          end
        end
        S_WB:    r_state <= S_FETCH;
        default: r_state <= S_FETCH;
      endcase
      if (w_retire) begin
        r_pc      <= w_pc_next;
        r_instret <= r_instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // requests are masked while reset is held, even though state is FETCH
  assign inst_req   = (r_state == S_FETCH) & ~reset;
  assign inst_addr  = r_pc;
  assign data_req   = (r_state == S_MEM) & ~reset;
  assign data_we    = data_req & w_st;
  assign data_addr  = r_alu;
  assign data_wdata = r_b;
  assign instret    = r_instret;

`ifdef MINICPU_TRACE_EN
  always_comb begin
    debug_wb_pc       = '0;
    debug_wb_rf_we    = 1'b0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    if (w_retire && !reset) begin
      debug_wb_pc = r_pc;
      if (w_rf_we && w_rd != 5'd0) begin
        debug_wb_rf_we    = 1'b1;
        debug_wb_rf_wnum  = w_rd;
        debug_wb_rf_wdata = w_wb_data;
      end
    end
  end
`endif
endmodule

// File: tb/tb_minicpu_multicycle.sv
// tb_minicpu_multicycle: ISA-level reference model driving req/ready memories.
// Trace outputs are checked when MINICPU_TRACE_EN is defined.
module tb_minicpu_multicycle;
  localparam logic [31:0] RPC = 32'h1c000000;
  localparam logic [16:0] OP_ADD  = 17'h00020;
  localparam logic [16:0] OP_SUB  = 17'h00022;
  localparam logic [9:0]  OP_ADDI = 10'h00a;
  localparam logic [9:0]  OP_LD   = 10'h0a2;
  localparam logic [9:0]  OP_ST   = 10'h0a6;
  localparam logic [5:0]  OP_BEQ  = 6'h16;
  localparam logic [5:0]  OP_BNE  = 6'h17;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req, inst_ready = 1'b0;
  logic [31:0] inst_addr, inst_rdata = '0;
  logic        data_req, data_we, data_ready = 1'b0;
  logic [31:0] data_addr, data_wdata, data_rdata = '0;
  logic [31:0] instret;
`ifdef MINICPU_TRACE_EN
  logic [31:0] tr_pc, tr_wdata;
  logic        tr_we;
  logic [4:0]  tr_wnum;
`endif

  minicpu_multicycle dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .data_req(data_req), .data_we(data_we),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_ready(data_ready),
    .instret(instret)
`ifdef MINICPU_TRACE_EN
    , .debug_wb_pc(tr_pc), .debug_wb_rf_we(tr_we),
    .debug_wb_rf_wnum(tr_wnum), .debug_wb_rf_wdata(tr_wdata)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instret;
  logic [31:0] m_rf [32];
  logic [31:0] m_mem [logic [31:0]];
  int          last_cyc, last_dcyc;
  logic [31:0] last_wdata, last_addr;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [16:0] op,
                                        input int rd, rj, rk);
    return {op, rk[4:0], rj[4:0], rd[4:0]};
  endfunction

  function automatic logic [31:0] enc_i(input logic [9:0] op,
                                        input int rd, rj, imm);
    return {op, imm[11:0], rj[4:0], rd[4:0]};
  endfunction

  function automatic logic [31:0] enc_b(input logic [5:0] op,
                                        input int rj, rd, offs);
    return {op, offs[15:0], rj[4:0], rd[4:0]};
  endfunction

  // Serves one instruction (wi fetch waits, wd data waits) and checks it
  task automatic run_inst(input logic [31:0] ins, input int wi, input int wd);
    logic [4:0]  rd, rj, rk;
    logic [31:0] a, imm, res, npc, eaddr;
    bit          is_ld, is_st, wr;
    int          base, cyc, dcyc, ntr;
    rd = ins[4:0]; rj = ins[9:5]; rk = ins[14:10];
    a = m_rf[rj];
    imm = 32'($signed(ins[21:10]));
    npc = m_pc + 32'd4;
    res = '0; eaddr = '0;
    is_ld = 0; is_st = 0; wr = 0; base = 3;
    cyc = 0; dcyc = 0; ntr = 0;
    if (ins[31:15] == OP_ADD) begin
      res = a + m_rf[rk]; wr = 1; base = 4;
    end else if (ins[31:15] == OP_SUB) begin
      res = a - m_rf[rk]; wr = 1; base = 4;
    end else if (ins[31:22] == OP_ADDI) begin
      res = a + imm; wr = 1; base = 4;
    end else if (ins[31:22] == OP_LD) begin
      eaddr = a + imm; is_ld = 1; wr = 1; base = 5 + wd;
      res = m_mem.exists(eaddr) ? m_mem[eaddr] : 32'd0;
    end else if (ins[31:22] == OP_ST) begin
      eaddr = a + imm; is_st = 1; base = 4 + wd;
    end else if (ins[31:26] == OP_BEQ) begin
      if (a == m_rf[rd]) npc = m_pc + (32'($signed(ins[25:10])) << 2);
    end else if (ins[31:26] == OP_BNE) begin
      if (a != m_rf[rd]) npc = m_pc + (32'($signed(ins[25:10])) << 2);
    end

    chk("fetch_req", {63'd0, inst_req}, 64'd1);
    chk("fetch_addr", {32'd0, inst_addr}, {32'd0, m_pc});
    chk("fetch_no_dreq", {63'd0, data_req}, 64'd0);
`ifdef MINICPU_TRACE_EN
    chk("trace_idle_pc", {32'd0, tr_pc}, 64'd0);
`endif
    for (int k = 0; k < wi; k++) begin
      inst_ready = 1'b0; inst_rdata = $urandom;
      data_ready = 1'($urandom); data_rdata = $urandom;
      @(negedge clk); cyc++;
      chk("fetch_hold_req", {63'd0, inst_req}, 64'd1);
      chk("fetch_hold_addr", {32'd0, inst_addr}, {32'd0, m_pc});
      chk("fetch_excl", {63'd0, data_req}, 64'd0);
    end
    inst_ready = 1'b1; inst_rdata = ins; data_ready = 1'($urandom);
    @(negedge clk); cyc++;

    while (!inst_req && cyc < 64) begin
      if (data_req) begin
        dcyc++;
        chk("data_addr", {32'd0, data_addr}, {32'd0, eaddr});
        chk("data_we", {63'd0, data_we}, {63'd0, is_st});
        if (is_st) chk("data_wdata", {32'd0, data_wdata}, {32'd0, m_rf[rd]});
        last_wdata = data_wdata; last_addr = data_addr;
        data_ready = (dcyc > wd);
        data_rdata = (data_ready && is_ld) ? res : $urandom;
      end else begin
        data_ready = 1'($urandom); data_rdata = $urandom;
      end
      inst_ready = 1'($urandom);
`ifdef MINICPU_TRACE_EN
      if (tr_pc !== 32'd0) begin
        ntr++;
        chk("trace_pc", {32'd0, tr_pc}, {32'd0, m_pc});
        chk("trace_we", {63'd0, tr_we}, {63'd0, wr && rd != 0});
        chk("trace_wnum", {59'd0, tr_wnum}, (wr && rd != 0) ? {59'd0, rd} : 64'd0);
        chk("trace_wdata", {32'd0, tr_wdata}, (wr && rd != 0) ? {32'd0, res} : 64'd0);
      end
`endif
      @(negedge clk); cyc++;
    end
    chk("timeout", {63'd0, inst_req}, 64'd1);
`ifdef MINICPU_TRACE_EN
    chk("trace_count", 64'(ntr), 64'd1);
`endif
    chk("latency", 64'(cyc), 64'(base + wi));
    chk("data_cycles", 64'(dcyc), (is_ld || is_st) ? 64'(wd + 1) : 64'd0);

    if (is_st) m_mem[eaddr] = m_rf[rd];
    if (wr && rd != 0) m_rf[rd] = res;
    m_pc = npc;
    m_instret = m_instret + 32'd1;
    chk("instret", {32'd0, instret}, {32'd0, m_instret});
    chk("next_pc", {32'd0, inst_addr}, {32'd0, m_pc});
    last_cyc = cyc; last_dcyc = dcyc;
  endtask

  initial begin
    int tot;
    logic [31:0] p, i0, w;
    for (int r = 0; r < 32; r++) m_rf[r] = '0;
    m_pc = RPC; m_instret = '0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_inst_req", {63'd0, inst_req}, 64'd0);
      chk("rst_data_req", {63'd0, data_req}, 64'd0);
      chk("rst_instret", {32'd0, instret}, 64'd0);
`ifdef MINICPU_TRACE_EN
      chk("rst_trace_we", {63'd0, tr_we}, 64'd0);
`endif
    end
    reset = 1'b0;
    @(negedge clk);
    chk("first_addr", {32'd0, inst_addr}, {32'd0, RPC});

    tot = 0;
    run_inst(enc_i(OP_ADDI, 1, 0, 5), 0, 0); tot += last_cyc;
    run_inst(enc_i(OP_ADDI, 2, 0, 3), 0, 0); tot += last_cyc;
    run_inst(enc_r(OP_SUB, 3, 1, 2), 0, 0); tot += last_cyc;
    run_inst(enc_r(OP_ADD, 4, 1, 2), 0, 0); tot += last_cyc;
    chk("alu_seq_cycles", 64'(tot), 64'd16);
    chk("alu_seq_instret", {32'd0, instret}, 64'd4);

    run_inst(enc_i(OP_ST, 4, 0, 'h10), 0, 3);
    chk("st_addr", {32'd0, last_addr}, 64'h10);
    chk("st_wdata", {32'd0, last_wdata}, 64'd8);
    chk("st_req_cycles", 64'(last_dcyc), 64'd4);
    run_inst(enc_i(OP_LD, 5, 0, 'h10), 0, 3);
    chk("ld_cycles", 64'(last_cyc), 64'd8);
    run_inst(enc_i(OP_ST, 5, 0, 'h14), 1, 0);
    chk("r5_value", {32'd0, last_wdata}, 64'd8);
    run_inst(enc_i(OP_ST, 3, 0, 'h18), 0, 1);
    chk("r3_value", {32'd0, last_wdata}, 64'd2);

    p = m_pc; run_inst(enc_b(OP_BNE, 1, 2, 2), 0, 0);
    chk("bne_taken", {32'd0, inst_addr}, {32'd0, p + 32'd8});
    p = m_pc; run_inst(enc_b(OP_BEQ, 1, 2, 2), 2, 0);
    chk("beq_not_taken", {32'd0, inst_addr}, {32'd0, p + 32'd4});
    p = m_pc; run_inst(enc_b(OP_BEQ, 1, 1, -1), 0, 0);
    chk("beq_backward", {32'd0, inst_addr}, {32'd0, p - 32'd4});

    i0 = m_instret;
    run_inst(enc_i(OP_ADDI, 0, 0, 7), 0, 0);
    chk("r0_write_retires", {32'd0, instret}, {32'd0, i0 + 32'd1});
    run_inst(enc_i(OP_ST, 0, 0, 'h1c), 0, 0);
    chk("r0_reads_zero", {32'd0, last_wdata}, 64'd0);
    p = m_pc;
    run_inst(32'hffffffff, 0, 0);
    chk("nop_pc", {32'd0, inst_addr}, {32'd0, p + 32'd4});
    chk("nop_cycles", 64'(last_cyc), 64'd3);

    // asynchronous reset while a fetch is waiting
    inst_ready = 1'b0; data_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_inst_req", {63'd0, inst_req}, 64'd0);
    chk("midrst_pc", {32'd0, inst_addr}, {32'd0, RPC});
    chk("midrst_instret", {32'd0, instret}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    m_pc = RPC; m_instret = '0;

    run_inst(enc_i(OP_ADDI, 6, 0, 'h7ff), 0, 0);
    run_inst(enc_i(OP_ADDI, 7, 0, -'d9), 1, 0);
    for (int n = 0; n < 160; n++) begin
      int k, rd, rj, rk, wi, wd;
      logic [31:0] ins;
      k  = $urandom_range(0, 8);
      rd = $urandom_range(0, 7); rj = $urandom_range(0, 7);
      rk = $urandom_range(0, 7);
      wi = $urandom_range(0, 3); wd = $urandom_range(0, 3);
      w  = $urandom;
      case (k)
        0: ins = enc_r(OP_ADD, rd, rj, rk);
        1: ins = enc_r(OP_SUB, rd, rj, rk);
        2: ins = enc_i(OP_ADDI, rd, rj, int'(w));
        3: ins = enc_i(OP_LD, rd, rj, int'(w));
        4: ins = enc_i(OP_ST, rd, rj, int'(w));
        5: ins = enc_b(OP_BEQ, rj, (n % 3 == 0) ? rj : rd, int'(w));
        6: ins = enc_b(OP_BNE, rj, rd, int'(w));
        7: begin
          ins = w;
          ins[4:3] = 2'b00; ins[9:8] = 2'b00; ins[14:13] = 2'b00;
        end
        default: ins = 32'hffffffff;
      endcase
      run_inst(ins, wi, wd);
    end
    inst_ready = 1'b0; data_ready = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
